// File: rtl/mem_access_unit.sv
// Load/store front end: validates core requests, drives a req/ack memory port,
// and returns size-extended load data.
//
// state | meaning
// IDLE  | waiting for memRead/memWrite from the decoder
// REQ   | mem_req held, waiting for mem_ack or timeout
// DONE  | access finished, one-cycle release of stall
// ERR   | illegal/misaligned request or timeout, err pulse
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    lat_off;
    logic [2:0]    lat_f3;

    logic          req_any;
    logic          illegal;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_ext;

    assign req_any = memRead | memWrite;
    assign illegal = (memRead & memWrite)
                   | (funct3[1:0] == 2'b11)
                   | ((funct3[1:0] == 2'b01) & addr[0])
                   | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00))
                   | (memWrite & funct3[2]);

    // stall must rise in the same cycle the core presents the request
    assign stall = (state == REQ) | ((state == IDLE) & req_any);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte  = mem_rdata[{lat_off, 3'b000} +: 8];
        ld_half  = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        case (lat_f3[1:0])
            2'b00:   load_ext = {{24{ld_byte[7] & ~lat_f3[2]}}, ld_byte};
            2'b01:   load_ext = {{16{ld_half[15] & ~lat_f3[2]}}, ld_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_off   <= 2'b00;
            lat_f3    <= 3'b000;
            rdata     <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (illegal) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= memWrite;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                            lat_off   <= addr[1:0];
                            lat_f3    <= funct3;
                            wait_cnt  <= '0;
                        end
                    end
                end
                REQ: begin
                    // ack takes precedence over a timeout in the same cycle
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) rdata <= load_ext;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ERR;
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // results of the last access
    int          stall_cyc, req_cyc, err_cnt, end_cyc;
    logic        end_err, end_mem_req, finished;
    logic        snap_we;
    logic [31:0] snap_addr, snap_wdata, end_rdata;
    logic [3:0]  snap_be;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; ack on the ack_after-th REQ cycle (0 = never).
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_after, input logic [31:0] rword);
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; wdata = wd;
        stall_cyc = 0; req_cyc = 0; err_cnt = 0; end_cyc = -1; finished = 1'b0;
        snap_we = 1'b0; snap_addr = '0; snap_wdata = '0; snap_be = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (mem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    snap_we = mem_we; snap_addr = mem_addr;
                    snap_be = mem_be; snap_wdata = mem_wdata;
                end
                if (req_cyc == ack_after) begin
                    mem_ack = 1'b1; mem_rdata = rword;
                end
            end
            #1;
            if (stall) stall_cyc++;
            if (err) err_cnt++;
            if (cyc > 0 && !stall) begin
                end_cyc = cyc; end_err = err; end_mem_req = mem_req; end_rdata = rdata;
                finished = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            memRead = 1'b0; memWrite = 1'b0; mem_ack = 1'b0;
        end
        if (!finished) check("access_bound", 32'd0, 32'd1);
        memRead = 1'b0; memWrite = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we",  {31'd0, mem_we},  32'd0);
        check("rst_err",     {31'd0, err},     32'd0);
        check("rst_stall",   {31'd0, stall},   32'd0);
        check("rst_mem_be",  {28'd0, mem_be},  32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        check("idle_ack_rdata", rdata, 32'd0);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);

        // lw 0x100, ack on third REQ cycle
        access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        check("lw_addr", snap_addr, 32'h100);
        check("lw_be", {28'd0, snap_be}, 32'hF);
        check("lw_we", {31'd0, snap_we}, 32'd0);
        check("lw_stall_cycles", stall_cyc, 4);
        check("lw_req_cycles", req_cyc, 3);
        check("lw_done_req", {31'd0, end_mem_req}, 32'd0);
        check("lw_rdata", end_rdata, 32'hDEADBEEF);
        check("lw_err", err_cnt, 0);

        // lb / lbu at 0x103
        access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h8000_0000);
        check("lb_be", {28'd0, snap_be}, 32'h8);
        check("lb_addr", snap_addr, 32'h100);
        check("lb_rdata", end_rdata, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h8000_0000);
        check("lbu_rdata", end_rdata, 32'h0000_0080);

        // sh at 0x206: rdata keeps the lbu result
        access(0, 1, 3'b001, 32'h206, 32'h1234_ABCD, 2, 32'h5555_5555);
        check("sh_be", {28'd0, snap_be}, 32'hC);
        check("sh_wdata", snap_wdata, 32'hABCD_ABCD);
        check("sh_we", {31'd0, snap_we}, 32'd1);
        check("sh_addr", snap_addr, 32'h204);
        check("sh_rdata_kept", end_rdata, 32'h0000_0080);

        // sb at 0x101, lh at 0x100 (signed, low half), lhu at 0x102
        access(0, 1, 3'b000, 32'h101, 32'h0000_0055, 1, 32'h0);
        check("sb_be", {28'd0, snap_be}, 32'h2);
        check("sb_wdata", snap_wdata, 32'h5555_5555);
        access(1, 0, 3'b001, 32'h100, 32'h0, 1, 32'h7777_8001);
        check("lh_be", {28'd0, snap_be}, 32'h3);
        check("lh_rdata", end_rdata, 32'hFFFF_8001);
        access(1, 0, 3'b101, 32'h102, 32'h0, 1, 32'h9ABC_0000);
        check("lhu_rdata", end_rdata, 32'h0000_9ABC);

        // misaligned lw 0x102
        access(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
        check("mis_req_cycles", req_cyc, 0);
        check("mis_err_cycle", end_cyc, 1);
        check("mis_err", {31'd0, end_err}, 32'd1);
        check("mis_stall_cycles", stall_cyc, 1);
        check("mis_err_pulse", {31'd0, err}, 32'd0);
        check("mis_rdata_kept", rdata, 32'h0000_9ABC);

        // illegal combinations
        access(1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0);
        check("both_err", err_cnt, 1);
        check("both_req", req_cyc, 0);
        access(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
        check("f3_11_err", err_cnt, 1);
        access(0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0);
        check("store_uns_err", err_cnt, 1);
        check("store_uns_req", req_cyc, 0);

        // timeout: no ack
        access(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
        check("to_req_cycles", req_cyc, 4);
        check("to_err", {31'd0, end_err}, 32'd1);
        check("to_mem_req", {31'd0, end_mem_req}, 32'd0);
        check("to_stall_cycles", stall_cyc, 5);

        // ack on the timeout cycle wins
        access(1, 0, 3'b010, 32'h304, 32'h0, 4, 32'h0BAD_F00D);
        check("tack_err", err_cnt, 0);
        check("tack_rdata", end_rdata, 32'h0BAD_F00D);

        // reset during REQ, then a stray ack
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h400;
        step();
        memRead = 1'b0;
        check("mid_req", {31'd0, mem_req}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_be", {28'd0, mem_be}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        check("late_ack_rdata", rdata, 32'd0);
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        check("late_ack_err", {31'd0, err}, 32'd0);

        // recovery after reset
        access(1, 0, 3'b010, 32'h500, 32'h0, 2, 32'h1357_9BDF);
        check("recov_rdata", end_rdata, 32'h1357_9BDF);
        check("recov_addr", snap_addr, 32'h500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum number of REQ-state cycles to wait for mem_ack.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port memRead, input, 1: load request from the control decoder.
REQ-005 SHALL have port memWrite, input, 1: store request from the control decoder.
REQ-006 SHALL have port funct3, input, 3: access size in [1:0] (00 byte, 01 half, 10 word, 11 illegal); [2]=1 selects an unsigned load.
REQ-007 SHALL have port addr, input, 32: byte address from the ALU.
REQ-008 SHALL have port wdata, input, 32: store data, taken from the low bits.
REQ-009 SHALL have port rdata, output, 32: registered, extended load result.
REQ-010 SHALL have port stall, output, 1: holds the core while high.
REQ-011 SHALL have port err, output, 1: one-cycle pulse on misalignment, illegal request or timeout.
REQ-012 SHALL have port mem_req, output, 1: memory request, held until accepted.
REQ-013 SHALL have port mem_we, output, 1: 1 = write.
REQ-014 SHALL have port mem_addr, output, 32: word-aligned address, with addr[1:0] forced to 00.
REQ-015 SHALL have port mem_be, output, 4: byte enables.
REQ-016 SHALL have port mem_wdata, output, 32: lane-replicated store data.
REQ-017 SHALL have port mem_ack, input, 1: memory completion.
REQ-018 SHALL have port mem_rdata, input, 32: read word, valid when mem_ack=1.

Function
REQ-019 SHALL implement the FSM states IDLE, REQ, DONE and ERR.
REQ-020 In IDLE with neither request, stall SHALL be 0, mem_req SHALL be 0, and the FSM SHALL stay in IDLE.
REQ-021 In IDLE with exactly one request that is legal and aligned, the unit SHALL:
- drive stall=1 combinationally;
- latch addr, funct3, mem_we, mem_be and mem_wdata;
- go to REQ.
REQ-022 In IDLE, the unit SHALL go to ERR with stall=1 and without asserting mem_req when any of these holds:
- memRead and memWrite are both 1;
- funct3[1:0]=11;
- a half access has addr[0]=1;
- a word access has addr[1:0]!=00;
- a store has funct3[2]=1.
REQ-023 In REQ, mem_req SHALL be 1 and stall SHALL be 1, with all mem_* outputs stable until mem_ack.
REQ-024 In REQ with mem_ack=1, the unit SHALL register rdata (loads only) and go to DONE.
REQ-025 In DONE, stall SHALL be 0 and mem_req SHALL be 0 for exactly one cycle, after which the FSM SHALL go to IDLE.
REQ-026 In ERR, err SHALL be 1, stall SHALL be 0 and mem_req SHALL be 0 for one cycle, after which the FSM SHALL go to IDLE.
REQ-027 The wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-028 When the wait counter reaches TIMEOUT-1 without ack, the FSM SHALL go to ERR.
REQ-029 When ack arrives in the same cycle as the timeout, ack SHALL win.
REQ-030 mem_ack SHALL be ignored outside REQ.
REQ-031 Byte enables SHALL be:
- byte access: 0001 shifted left by addr[1:0];
- half access: 0011 when addr[1]=0, 1100 when addr[1]=1;
- word access: 1111.
REQ-032 Store data SHALL be:
- byte: wdata[7:0] replicated into all 4 lanes;
- half: wdata[15:0] replicated into both halves;
- word: wdata unchanged.
REQ-033 Loads SHALL select the byte or half from mem_rdata by the latched addr[1:0].
REQ-034 The selected load value SHALL be sign-extended to 32 bits when funct3[2]=0 and zero-extended when funct3[2]=1.
REQ-035 rdata SHALL hold its value until the next completed load.
REQ-036 On a store completion, rdata SHALL be unchanged.
REQ-037 A request present in the cycle after DONE SHALL be treated as a new access.

Reset
REQ-038 On rst=1 at a clock edge the unit SHALL set:
- state to IDLE;
- mem_req, mem_we, err and the wait counter to 0;
- mem_be to 0000;
- mem_addr, mem_wdata and rdata to 0.
REQ-039 rst SHALL take priority in every state, including mid-REQ; mem_req SHALL be 0 from the cycle after the reset edge.
REQ-040 A late mem_ack arriving after reset SHALL be ignored.

Verification
REQ-041 The bench SHALL cover a word load:
- stimulus: lw at addr=0x100, ack after 3 cycles with mem_rdata=0xDEADBEEF;
- response: mem_addr=0x100, mem_be=1111, stall high for 4 cycles, then DONE with rdata=0xDEADBEEF.
REQ-042 The bench SHALL cover a signed and an unsigned byte load:
- stimulus: lb then lbu at addr=0x103, mem_rdata=0x80000000;
- response: rdata=0xFFFFFF80 for lb, then 0x00000080 for lbu.
REQ-043 The bench SHALL cover a half store:
- stimulus: sh at addr=0x206 with wdata=0x1234ABCD;
- response: mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, rdata unchanged.
REQ-044 The bench SHALL cover a misaligned access:
- stimulus: lw at addr=0x102;
- response: no mem_req, err pulses 1 cycle in the second cycle, stall=0 in that cycle.
REQ-045 The bench SHALL cover a timeout:
- stimulus: TIMEOUT=4, mem_ack never asserted;
- response: ERR after 4 REQ cycles, err=1, mem_req drops.
REQ-046 The bench SHALL cover reset mid-transaction:
- stimulus: rst during REQ, followed by a stray mem_ack;
- response: state returns to IDLE, all outputs at reset values, the ack is ignored.
